// File: rtl/idu_alu_iq_pkg.sv
// Shared types, widths and opcode constants for the ALU issue queue.
package idu_alu_iq_pkg;

   localparam int unsigned IID_W  = 4;
   localparam int unsigned PREG_W = 6;
   localparam int unsigned XLEN   = 64;

   localparam logic [6:0] R_ALU64 = 7'b0110011;
   localparam logic [6:0] R_ALU32 = 7'b0111011;
   localparam logic [6:0] I_ALU64 = 7'b0010011;
   localparam logic [6:0] I_ALU32 = 7'b0011011;
   localparam logic [6:0] U_AUIPC = 7'b0010111;
   localparam logic [6:0] U_LUI   = 7'b0110111;

   typedef struct packed {
      logic              vld;
      logic              rdy;
      logic [PREG_W-1:0] preg;
      logic [XLEN-1:0]   value;
   } src_t;

   typedef struct packed {
      logic              vld;
      logic [PREG_W-1:0] preg;
      logic [XLEN-1:0]   data;
   } wb_t;

   typedef struct packed {
      logic [IID_W-1:0]  iid;
      logic [6:0]        opcode;
      logic [6:0]        funct7;
      logic [2:0]        funct3;
      logic [XLEN-1:0]   pc;
      src_t              src1;
      src_t              src2;
      logic              pdst_vld;
      logic [PREG_W-1:0] pdst;
      logic              imm_vld;
      logic [XLEN-1:0]   imm;
   } iq_entry_t;

   typedef struct packed {
      logic [IID_W-1:0]  iid;
      logic [6:0]        opcode;
      logic [6:0]        funct7;
      logic [2:0]        funct3;
      logic [XLEN-1:0]   pc;
      logic              psrc1_vld;
      logic [XLEN-1:0]   psrc1_value;
      logic              psrc2_vld;
      logic [XLEN-1:0]   psrc2_value;
      logic              pdst_vld;
      logic [PREG_W-1:0] pdst;
      logic              imm_vld;
      logic [XLEN-1:0]   imm;
   } iss_t;

   // Resolve a pending source against both writeback buses; ALU bus wins a tie.
   function automatic src_t src_wake(input src_t s, input wb_t alu, input wb_t lsu);
      src_t r;
      r = s;
      if (s.vld && !s.rdy) begin
         if (alu.vld && (alu.preg == s.preg)) begin
            r.rdy   = 1'b1;
            r.value = alu.data;
         end else if (lsu.vld && (lsu.preg == s.preg)) begin
            r.rdy   = 1'b1;
            r.value = lsu.data;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/idu_alu_iq_entry.sv
// One issue-queue slot: payload storage, source ready bits and writeback capture.
module idu_alu_iq_entry
   import idu_alu_iq_pkg::*;
(
   input  logic      clk,
   input  logic      rst_clk,
   input  logic      flush,
   input  logic      wr_en,
   input  logic      clr,
   input  iq_entry_t wr_data,
   input  wb_t       alu_wb,
   input  wb_t       lsu_wb,
   output logic      rdy,
   output iss_t      pay
);

   logic      vld_q;
   iq_entry_t ent_q;
   iq_entry_t ent_wake;
   iq_entry_t wr_wake;

   // Wakeup applies both to the resident payload and to a same-cycle write.
   always_comb begin
      ent_wake      = ent_q;
      ent_wake.src1 = src_wake(ent_q.src1, alu_wb, lsu_wb);
      ent_wake.src2 = src_wake(ent_q.src2, alu_wb, lsu_wb);
      wr_wake       = wr_data;
      wr_wake.src1  = src_wake(wr_data.src1, alu_wb, lsu_wb);
      wr_wake.src2  = src_wake(wr_data.src2, alu_wb, lsu_wb);
   end

   always_ff @(posedge clk or negedge rst_clk) begin
      if (!rst_clk) begin
         vld_q <= 1'b0;
         ent_q <= '0;
      end else if (flush) begin
         vld_q <= 1'b0;
      end else if (wr_en) begin
         vld_q <= 1'b1;
         ent_q <= wr_wake;
      end else if (clr) begin
         vld_q <= 1'b0;
      end else if (vld_q) begin
         ent_q <= ent_wake;
      end
   end

   always_comb begin
      rdy             = ent_q.src1.rdy & ent_q.src2.rdy;
      pay             = '0;
      pay.iid         = ent_q.iid;
      pay.opcode      = ent_q.opcode;
      pay.funct7      = ent_q.funct7;
      pay.funct3      = ent_q.funct3;
      pay.pc          = ent_q.pc;
      pay.psrc1_vld   = ent_q.src1.vld;
      pay.psrc1_value = ent_q.src1.value;
      pay.psrc2_vld   = ent_q.src2.vld;
      pay.psrc2_value = ent_q.src2.value;
      pay.pdst_vld    = ent_q.pdst_vld;
      pay.pdst        = ent_q.pdst;
      pay.imm_vld     = ent_q.imm_vld;
      pay.imm         = ent_q.imm;
   end

endmodule

// File: rtl/idu_alu_iq.sv
// In-order ALU issue queue: buffers dispatched ops, wakes sources from writeback, issues the head.
module idu_alu_iq
   import idu_alu_iq_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic              clk,
   input  logic              rst_clk,
   input  logic              rtu_global_flush,
   input  logic              dis_iq_vld,
   input  logic [IID_W-1:0]  dis_iq_iid,
   input  logic [6:0]        dis_iq_opcode,
   input  logic [6:0]        dis_iq_funct7,
   input  logic [2:0]        dis_iq_funct3,
   input  logic [XLEN-1:0]   dis_iq_pc,
   input  logic              dis_iq_psrc1_vld,
   input  logic              dis_iq_psrc1_rdy,
   input  logic [PREG_W-1:0] dis_iq_psrc1_preg,
   input  logic [XLEN-1:0]   dis_iq_psrc1_value,
   input  logic              dis_iq_psrc2_vld,
   input  logic              dis_iq_psrc2_rdy,
   input  logic [PREG_W-1:0] dis_iq_psrc2_preg,
   input  logic [XLEN-1:0]   dis_iq_psrc2_value,
   input  logic              dis_iq_pdst_vld,
   input  logic [PREG_W-1:0] dis_iq_pdst,
   input  logic              dis_iq_imm_vld,
   input  logic [XLEN-1:0]   dis_iq_imm,
   output logic              iq_dis_full,
   input  logic              exu_idu_rf_alu_wb_vld,
   input  logic [PREG_W-1:0] exu_idu_rf_alu_wb_preg,
   input  logic [XLEN-1:0]   exu_idu_rf_alu_wb_data,
   input  logic              exu_idu_rf_lsu_wb_vld,
   input  logic [PREG_W-1:0] exu_idu_rf_lsu_wb_preg,
   input  logic [XLEN-1:0]   exu_idu_rf_lsu_wb_data,
   output logic              idu_exu_alu_vld,
   output logic [IID_W-1:0]  idu_exu_alu_iid,
   output logic [6:0]        idu_exu_alu_opcode,
   output logic [6:0]        idu_exu_alu_funct7,
   output logic [2:0]        idu_exu_alu_funct3,
   output logic [XLEN-1:0]   idu_exu_alu_pc,
   output logic              idu_exu_alu_psrc1_vld,
   output logic [XLEN-1:0]   idu_exu_alu_psrc1_value,
   output logic              idu_exu_alu_psrc2_vld,
   output logic [XLEN-1:0]   idu_exu_alu_psrc2_value,
   output logic              idu_exu_alu_pdst_vld,
   output logic [PREG_W-1:0] idu_exu_alu_pdst,
   output logic              idu_exu_alu_imm_vld,
   output logic [XLEN-1:0]   idu_exu_alu_imm
);

   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [PTR_W:0]   count_q;
   logic             full;
   logic             enq;
   logic             issue_en;
   wb_t              alu_wb;
   wb_t              lsu_wb;
   iq_entry_t        dis_ent;
   iss_t             iss;
   logic [DEPTH-1:0] ent_rdy;
   iss_t             ent_pay [DEPTH];

   assign alu_wb = '{vld: exu_idu_rf_alu_wb_vld, preg: exu_idu_rf_alu_wb_preg,
                     data: exu_idu_rf_alu_wb_data};
   assign lsu_wb = '{vld: exu_idu_rf_lsu_wb_vld, preg: exu_idu_rf_lsu_wb_preg,
                     data: exu_idu_rf_lsu_wb_data};

   assign full        = (count_q == (PTR_W+1)'(DEPTH));
   assign iq_dis_full = full;
   assign enq         = dis_iq_vld & ~full & ~rtu_global_flush;
   assign issue_en    = (count_q != '0) & ent_rdy[head_q] & ~rtu_global_flush;

   // Unused sources enter as ready with a zero value so they never gate issue.
   always_comb begin
      dis_ent             = '0;
      dis_ent.iid         = dis_iq_iid;
      dis_ent.opcode      = dis_iq_opcode;
      dis_ent.funct7      = dis_iq_funct7;
      dis_ent.funct3      = dis_iq_funct3;
      dis_ent.pc          = dis_iq_pc;
      dis_ent.src1.vld    = dis_iq_psrc1_vld;
      dis_ent.src1.rdy    = ~dis_iq_psrc1_vld | dis_iq_psrc1_rdy;
      dis_ent.src1.preg   = dis_iq_psrc1_preg;
      dis_ent.src1.value  = dis_iq_psrc1_vld ? dis_iq_psrc1_value : '0;
      dis_ent.src2.vld    = dis_iq_psrc2_vld;
      dis_ent.src2.rdy    = ~dis_iq_psrc2_vld | dis_iq_psrc2_rdy;
      dis_ent.src2.preg   = dis_iq_psrc2_preg;
      dis_ent.src2.value  = dis_iq_psrc2_vld ? dis_iq_psrc2_value : '0;
      dis_ent.pdst_vld    = dis_iq_pdst_vld;
      dis_ent.pdst        = dis_iq_pdst;
      dis_ent.imm_vld     = dis_iq_imm_vld;
      dis_ent.imm         = dis_iq_imm;
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      idu_alu_iq_entry u_entry (
         .clk     (clk),
         .rst_clk (rst_clk),
         .flush   (rtu_global_flush),
         .wr_en   (enq && (tail_q == PTR_W'(i))),
         .clr     (issue_en && (head_q == PTR_W'(i))),
         .wr_data (dis_ent),
         .alu_wb  (alu_wb),
         .lsu_wb  (lsu_wb),
         .rdy     (ent_rdy[i]),
         .pay     (ent_pay[i])
      );
   end

   always_ff @(posedge clk or negedge rst_clk) begin
      if (!rst_clk) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (rtu_global_flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (enq)      tail_q <= tail_q + PTR_W'(1);
         if (issue_en) head_q <= head_q + PTR_W'(1);
         count_q <= count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(issue_en);
      end
   end

   // Issue payload comes only from registered head state, zeroed when not issuing.
   assign iss = issue_en ? ent_pay[head_q] : '0;

   assign idu_exu_alu_vld         = issue_en;
   assign idu_exu_alu_iid         = iss.iid;
   assign idu_exu_alu_opcode      = iss.opcode;
   assign idu_exu_alu_funct7      = iss.funct7;
   assign idu_exu_alu_funct3      = iss.funct3;
   assign idu_exu_alu_pc          = iss.pc;
   assign idu_exu_alu_psrc1_vld   = iss.psrc1_vld;
   assign idu_exu_alu_psrc1_value = iss.psrc1_value;
   assign idu_exu_alu_psrc2_vld   = iss.psrc2_vld;
   assign idu_exu_alu_psrc2_value = iss.psrc2_value;
   assign idu_exu_alu_pdst_vld    = iss.pdst_vld;
   assign idu_exu_alu_pdst        = iss.pdst;
   assign idu_exu_alu_imm_vld     = iss.imm_vld;
   assign idu_exu_alu_imm         = iss.imm;

endmodule

// File: doc/idu_alu_iq.md
Name: idu_alu_iq

Overview:
In-order issue queue for the ALU pipe. It sits between dispatch and exu_alu.
- Buffers dispatched ALU instructions.
- Wakes up pending source operands from the ALU and LSU writeback buses, capturing the data.
- Issues the head entry to exu_alu once all valid sources are ready.

Parameters:
DEPTH, 4, number of entries (power of 2).
PTR_W, 2, log2(DEPTH). The count register is PTR_W+1 bits.

Ports:
clk  input  1  clock
rst_clk  input  1  asynchronous active-low reset
rtu_global_flush  input  1  kill all entries
dis_iq_vld  input  1  dispatch request
dis_iq_iid / opcode / funct7 / funct3 / pc  input  4 / 7 / 7 / 3 / 64  decoded instruction fields
dis_iq_psrc1_vld, dis_iq_psrc1_rdy, dis_iq_psrc1_preg, dis_iq_psrc1_value  input  1, 1, 6, 64  source 1 (value meaningful only if rdy)
dis_iq_psrc2_vld, dis_iq_psrc2_rdy, dis_iq_psrc2_preg, dis_iq_psrc2_value  input  1, 1, 6, 64  source 2
dis_iq_pdst_vld, dis_iq_pdst, dis_iq_imm_vld, dis_iq_imm  input  1, 6, 1, 64  destination and immediate
iq_dis_full  output  1  queue full; dispatch must not assert while high
exu_idu_rf_alu_wb_vld, exu_idu_rf_alu_wb_preg, exu_idu_rf_alu_wb_data  input  1, 6, 64  ALU writeback bus
exu_idu_rf_lsu_wb_vld, exu_idu_rf_lsu_wb_preg, exu_idu_rf_lsu_wb_data  input  1, 6, 64  LSU writeback bus
idu_exu_alu_vld  output  1  issue valid
idu_exu_alu_{iid, opcode, funct7, funct3, pc, psrc1_vld, psrc1_value, psrc2_vld, psrc2_value, pdst_vld, pdst, imm_vld, imm}  output  same widths as dispatch  issued fields

Behaviour:
- Clock and reset: single clock clk; rst_clk is asynchronous, active-low. On reset:
  - head = tail = count = 0; all entries invalid.
  - iq_dis_full = 0; idu_exu_alu_vld = 0; every idu_exu_alu_* output = 0.
- Storage: circular buffer of DEPTH entries. Each entry holds all dispatch fields plus src1_rdy / src2_rdy.
  - Pointers wrap modulo DEPTH.
  - full = (count == DEPTH); iq_dis_full = full, registered-state derived.
- Enqueue: when dis_iq_vld & ~full & ~flush, write entry[tail] and set tail++.
  - A source with psrc_vld = 0 is stored as rdy = 1, value = 0.
  - Dispatch while full is dropped. No credit for a same-cycle issue, so full blocks enqueue even if the head issues that cycle.
- Dispatch-cycle capture: an incoming source with vld & ~rdy whose preg matches a wb bus with wb_vld in the same cycle is stored rdy = 1 with that wb data.
- Wakeup: each valid entry source with ~rdy and preg == wb_preg & wb_vld sets rdy = 1 next cycle and latches the wb data.
  - If both buses match, ALU data wins.
  - Ready sources ignore wb.
- Issue: issue_en = (count != 0) & src1_rdy[head] & src2_rdy[head] & ~rtu_global_flush.
  - idu_exu_alu_* are combinational from entry[head], AND-gated by issue_en; all fields are 0 when not issuing.
  - No combinational path from dis_* or wb inputs to the issue outputs.
  - On issue, head++ and the entry is invalidated.
- Strict in order: younger ready entries never bypass a waiting head.
- Latency: dispatch at cycle T with ready sources gives earliest issue at T+1. A wakeup at cycle N gives issue at N+1. Throughput is 1 per cycle.
- count update: count + enq - issue. Simultaneous enq and issue leaves count unchanged.
- Flush: in the flush cycle, issue is suppressed and dispatch dropped. Next cycle head = tail = count = 0 and all entries are invalid. Flush has priority over everything except reset.
- Reset mid-operation: contents are discarded immediately (async).

Decomposition:
- Shared define file: opcode constants (R_ALU64, R_ALU32, I_ALU64, I_ALU32, U_AUIPC, U_LUI), IID_W = 4, PREG_W = 6, XLEN = 64.
- Sub-module idu_alu_iq_entry: one entry's storage, ready bits, and two-bus wakeup compare/capture. Instantiated DEPTH times; top holds pointers, count, full and the issue mux.

Test Plan:
1. Reset -> iq_dis_full = 0, idu_exu_alu_vld = 0, all idu_exu_alu_* = 0.
2. Dispatch ADD at T with iid = 3, both sources ready, psrc1_value = 5, psrc2_value = 7 -> at T+1: vld = 1, iid = 3, values 5/7. Queue empty at T+2.
3. Dispatch at T with src1 ~rdy, preg = 12; ALU wb preg 12, data 0x55 at T+3 -> vld first at T+4, psrc1_value = 0x55.
4. A (waiting on preg 9) then B (ready) -> no issue until LSU wb preg 9 at N; A issues N+1, B issues N+2.
5. Four dispatches with a blocked head -> iq_dis_full = 1. A 5th dispatch is dropped. Wakeup drains 4 issues on consecutive cycles; iq_dis_full falls after the first issue.
6. Three entries queued, flush plus dispatch at T -> vld = 0 at T. At T+1: empty, iq_dis_full = 0, and the dispatched instruction never issues.
